// File: rtl/call_ret_seq.sv
// ============================================================================
// Module   : call_ret_seq
// Purpose  : PC sequencer for CALL/RET/JUMP/STEP driving an 8-bit hardware
//            stack, with a shadow depth count and sticky ovf/udf flags.
//            Optional macro CALL_RET_HWM_EN adds the hwm (high-water) output.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module call_ret_seq #(
    parameter int         DEPTH  = 255,
    parameter int         RD_LAT = 0,
    parameter logic [7:0] RST_PC = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       call,
    input  logic       ret,
    input  logic       jump,
    input  logic       step,
    input  logic [7:0] target,
    input  logic [7:0] stk_data,
    output logic [7:0] pc,
    output logic       busy,
    output logic       stk_push,
    output logic       stk_pop,
    output logic [7:0] stk_value,
    output logic [7:0] depth,
`ifdef CALL_RET_HWM_EN
    output logic [7:0] hwm,
`endif
    output logic       ovf,
    output logic       udf
);

    localparam logic [7:0] DEPTH_MAX = 8'(DEPTH);

    typedef enum logic [0:0] {
        S_IDLE     = 1'b0,
        S_RET_WAIT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] depth_q, depth_d;
    logic       ovf_q, ovf_d;
    logic       udf_q, udf_d;
    logic [7:0] pc_inc;

    assign pc_inc = pc_q + 8'd1;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        depth_d  = depth_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        busy     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (call) begin
                    if (depth_q < DEPTH_MAX) begin
                        stk_push = 1'b1;
                        pc_d     = target;
                        depth_d  = depth_q + 8'd1;
                    end else begin
                        ovf_d = 1'b1;
                        pc_d  = pc_inc;
                    end
                end else if (ret) begin
                    if (depth_q == 8'd0) begin
                        udf_d = 1'b1;
                        pc_d  = pc_inc;
                    end else begin
                        stk_pop = 1'b1;
                        depth_d = depth_q - 8'd1;
                        // Slow stack: data arrives a cycle after the pop strobe.
                        if (RD_LAT == 0) pc_d = stk_data;
                        else             state_d = S_RET_WAIT;
                    end
                end else if (jump) begin
                    pc_d = target;
                end else if (step) begin
                    pc_d = pc_inc;
                end
            end
            S_RET_WAIT: begin
                busy    = 1'b1;
                pc_d    = stk_data;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RST_PC;
            depth_q <= 8'd0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

`ifdef CALL_RET_HWM_EN
    logic [7:0] hwm_q, hwm_d;

    assign hwm_d = (depth_d > hwm_q) ? depth_d : hwm_q;

    always_ff @(posedge clk) begin
        if (rst) hwm_q <= 8'd0;
        else     hwm_q <= hwm_d;
    end

    assign hwm = hwm_q;
`endif

    assign pc        = pc_q;
    assign depth     = depth_q;
    assign ovf       = ovf_q;
    assign udf       = udf_q;
    assign stk_value = stk_push ? pc_inc : 8'd0;

endmodule

`default_nettype wire

// File: tb/tb_call_ret_seq.sv
// ============================================================================
// Module   : tb_call_ret_seq
// Purpose  : Directed self-checking bench for call_ret_seq; instance A uses
//            RD_LAT=0/DEPTH=255, instance B uses RD_LAT=1/DEPTH=2/RST_PC=05.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_call_ret_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Instance A signals
    logic       a_rst = 1'b1, a_call = 1'b0, a_ret = 1'b0, a_jump = 1'b0, a_step = 1'b0;
    logic [7:0] a_target = 8'h00, a_sdata = 8'h00;
    logic [7:0] a_pc, a_sval, a_depth;
    logic       a_busy, a_push, a_pop, a_ovf, a_udf;

    // Instance B signals
    logic       b_rst = 1'b1, b_call = 1'b0, b_ret = 1'b0, b_jump = 1'b0, b_step = 1'b0;
    logic [7:0] b_target = 8'h00, b_sdata = 8'h00;
    logic [7:0] b_pc, b_sval, b_depth;
    logic       b_busy, b_push, b_pop, b_ovf, b_udf;
`ifdef CALL_RET_HWM_EN
    logic [7:0] a_hwm, b_hwm;
`endif

    call_ret_seq #(.DEPTH(255), .RD_LAT(0), .RST_PC(8'h00)) u_dut_a (
        .clk(clk), .rst(a_rst), .call(a_call), .ret(a_ret), .jump(a_jump),
        .step(a_step), .target(a_target), .stk_data(a_sdata), .pc(a_pc),
        .busy(a_busy), .stk_push(a_push), .stk_pop(a_pop), .stk_value(a_sval),
        .depth(a_depth),
`ifdef CALL_RET_HWM_EN
        .hwm(a_hwm),
`endif
        .ovf(a_ovf), .udf(a_udf)
    );

    call_ret_seq #(.DEPTH(2), .RD_LAT(1), .RST_PC(8'h05)) u_dut_b (
        .clk(clk), .rst(b_rst), .call(b_call), .ret(b_ret), .jump(b_jump),
        .step(b_step), .target(b_target), .stk_data(b_sdata), .pc(b_pc),
        .busy(b_busy), .stk_push(b_push), .stk_pop(b_pop), .stk_value(b_sval),
        .depth(b_depth),
`ifdef CALL_RET_HWM_EN
        .hwm(b_hwm),
`endif
        .ovf(b_ovf), .udf(b_udf)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic a_idle();
        a_call = 1'b0; a_ret = 1'b0; a_jump = 1'b0; a_step = 1'b0;
    endtask

    task automatic b_idle();
        b_call = 1'b0; b_ret = 1'b0; b_jump = 1'b0; b_step = 1'b0;
    endtask

    initial begin
        // ---------------- Instance A: RD_LAT=0 ----------------
        cyc(); cyc();
        a_rst = 1'b0;
        #1;
        chk("a_rst_pc", a_pc, 8'h00);
        chk("a_rst_depth", a_depth, 8'h00);
        chk("a_rst_ovf", a_ovf, 1'b0);
        chk("a_rst_udf", a_udf, 1'b0);
        chk("a_rst_busy", a_busy, 1'b0);

        for (int i = 1; i <= 3; i++) begin
            a_step = 1'b1; #1;
            chk("a_step_push", a_push, 1'b0);
            chk("a_step_pop", a_pop, 1'b0);
            cyc();
            chk("a_step_pc", a_pc, 16'(i));
            chk("a_step_depth", a_depth, 8'h00);
        end
        a_idle();

        a_jump = 1'b1; a_target = 8'h10; cyc(); a_idle();
        chk("a_jump_pc", a_pc, 8'h10);
        cyc();
        chk("a_hold_pc", a_pc, 8'h10);

        a_call = 1'b1; a_target = 8'h40; #1;
        chk("a_call_push", a_push, 1'b1);
        chk("a_call_pop", a_pop, 1'b0);
        chk("a_call_sval", a_sval, 8'h11);
        cyc(); a_idle(); #1;
        chk("a_call_pc", a_pc, 8'h40);
        chk("a_call_depth", a_depth, 8'h01);
        chk("a_idle_push", a_push, 1'b0);
        chk("a_idle_sval", a_sval, 8'h00);

        a_ret = 1'b1; a_sdata = 8'h11; #1;
        chk("a_ret_pop", a_pop, 1'b1);
        chk("a_ret_push", a_push, 1'b0);
        chk("a_ret_busy", a_busy, 1'b0);
        cyc(); a_idle(); #1;
        chk("a_ret_pc", a_pc, 8'h11);
        chk("a_ret_depth", a_depth, 8'h00);
        chk("a_ret_pop_once", a_pop, 1'b0);

        a_jump = 1'b1; a_target = 8'h07; cyc(); a_idle();
        a_ret = 1'b1; #1;
        chk("a_udf_pop", a_pop, 1'b0);
        cyc(); a_idle();
        chk("a_udf_flag", a_udf, 1'b1);
        chk("a_udf_pc", a_pc, 8'h08);
        chk("a_udf_depth", a_depth, 8'h00);
        a_step = 1'b1; cyc(); a_idle();
        chk("a_udf_sticky", a_udf, 1'b1);

        a_jump = 1'b1; a_target = 8'hFF; cyc(); a_idle();
        a_call = 1'b1; a_ret = 1'b1; a_jump = 1'b1; a_target = 8'h80; a_sdata = 8'h33; #1;
        chk("a_prio_push", a_push, 1'b1);
        chk("a_prio_pop", a_pop, 1'b0);
        chk("a_prio_sval", a_sval, 8'h00);
        cyc(); a_idle();
        chk("a_prio_pc", a_pc, 8'h80);
        chk("a_prio_depth", a_depth, 8'h01);

        a_rst = 1'b1; a_call = 1'b1; cyc(); a_rst = 1'b0; a_idle();
        chk("a_rst2_pc", a_pc, 8'h00);
        chk("a_rst2_udf", a_udf, 1'b0);
        chk("a_rst2_depth", a_depth, 8'h00);
`ifdef CALL_RET_HWM_EN
        chk("a_rst2_hwm", a_hwm, 8'h00);
`endif

        // ---------------- Instance B: RD_LAT=1, DEPTH=2 ----------------
        cyc();
        b_rst = 1'b0;
        #1;
        chk("b_rst_pc", b_pc, 8'h05);
        chk("b_rst_busy", b_busy, 1'b0);

        b_call = 1'b1; b_target = 8'h20; #1;
        chk("b_call1_sval", b_sval, 8'h06);
        cyc();
        chk("b_call1_pc", b_pc, 8'h20);
        b_target = 8'h30; #1;
        chk("b_call2_push", b_push, 1'b1);
        chk("b_call2_sval", b_sval, 8'h21);
        cyc(); b_idle();
        chk("b_call2_pc", b_pc, 8'h30);
        chk("b_call2_depth", b_depth, 8'h02);

        b_ret = 1'b1; b_sdata = 8'h21; #1;
        chk("b_ret_pop", b_pop, 1'b1);
        chk("b_ret_busy0", b_busy, 1'b0);
        cyc(); b_idle(); b_step = 1'b1; #1;
        chk("b_wait_busy", b_busy, 1'b1);
        chk("b_wait_pop", b_pop, 1'b0);
        chk("b_wait_push", b_push, 1'b0);
        chk("b_wait_depth", b_depth, 8'h01);
        chk("b_wait_pc", b_pc, 8'h30);
        cyc(); b_idle(); #1;
        chk("b_ret_pc", b_pc, 8'h21);
        chk("b_ret_busy1", b_busy, 1'b0);

        b_call = 1'b1; b_target = 8'h50; cyc();
        chk("b_call3_depth", b_depth, 8'h02);
        b_target = 8'h60; #1;
        chk("b_ovf_push", b_push, 1'b0);
        cyc(); b_idle();
        chk("b_ovf_flag", b_ovf, 1'b1);
        chk("b_ovf_pc", b_pc, 8'h51);
        chk("b_ovf_depth", b_depth, 8'h02);
`ifdef CALL_RET_HWM_EN
        chk("b_hwm", b_hwm, 8'h02);
`endif
        b_step = 1'b1; cyc(); b_idle();
        chk("b_ovf_sticky", b_ovf, 1'b1);
        chk("b_step_pc", b_pc, 8'h52);

        b_ret = 1'b1; b_sdata = 8'h51; cyc(); b_idle();
        b_rst = 1'b1; cyc(); b_rst = 1'b0; #1;
        chk("b_rst2_pc", b_pc, 8'h05);
        chk("b_rst2_busy", b_busy, 1'b0);
        chk("b_rst2_depth", b_depth, 8'h00);
        chk("b_rst2_ovf", b_ovf, 1'b0);
        cyc();
        chk("b_rst2_hold", b_pc, 8'h05);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
